// File: rtl/tcpc_prl_pkg.sv
// Shared types and constants for the TCPC protocol-layer transmit path.
package tcpc_prl_pkg;

   localparam int MSGID_W = 3;

   localparam logic PHY_SEL_MSG  = 1'b0;
   localparam logic PHY_SEL_GCRC = 1'b1;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      GCRC_TX  = 3'd1,
      MSG_TX   = 3'd2,
      WAIT_CRC = 3'd3,
      RETRY    = 3'd4
   } prl_tx_state_e;

endpackage

// File: rtl/crc_receive_timer.sv
// CRCReceiveTimer: loadable down-counter with a one-cycle expiry pulse.
module crc_receive_timer #(
   parameter int CRC_TIMEOUT = 1000
) (
   input  logic clk,
   input  logic reset,
   input  logic load_i,
   input  logic clear_i,
   output logic expired_o
);

   localparam int W = $clog2(CRC_TIMEOUT + 1);
   localparam logic [W-1:0] LOAD_V = W'(CRC_TIMEOUT);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = LOAD_V;
      else if (clear_i)
         cnt_d = '0;
      else if (cnt_q != '0)
         cnt_d = cnt_q - W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   // Count of 1 is the cycle CRC_TIMEOUT cycles after the load cycle.
   assign expired_o = (cnt_q == W'(1));

endmodule

// File: rtl/prl_tx_arbiter.sv
// PHY transmit arbiter: GoodCRC vs. message, retries and MessageID counter.
// Optional soft-reset MessageID clear enabled by TCPC_MSGID_CLEAR_EN.
module prl_tx_arbiter
   import tcpc_prl_pkg::*;
#(
   parameter int CRC_TIMEOUT = 1000,
   parameter int MAX_RETRY   = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               goodcrc_req,
   output logic               goodcrc_complete,
   output logic               goodcrc_discarded,
   input  logic               msg_req,
   input  logic [1:0]         msg_retries,
   output logic               msg_success,
   output logic               msg_failed,
   output logic               msg_discarded,
   input  logic               rx_goodcrc_valid,
   input  logic [MSGID_W-1:0] rx_goodcrc_id,
   output logic               unexpected_goodcrc,
   input  logic               phy_bus_idle,
   input  logic               phy_tx_done,
`ifdef TCPC_MSGID_CLEAR_EN
   input  logic               msgid_clear,
`endif
   output logic               phy_tx_start,
   output logic               phy_tx_sel,
   output logic [MSGID_W-1:0] phy_tx_id
);

   localparam logic [1:0] MAX_R = (MAX_RETRY > 3) ? 2'd3 : 2'(MAX_RETRY);

   prl_tx_state_e      state_q, state_d;
   logic [MSGID_W-1:0] msgid_q, msgid_d;
   logic [1:0]         retry_q, retry_d;
   logic               start_q, start_d;
   logic               sel_q, sel_d;
   logic [MSGID_W-1:0] id_q, id_d;
   logic               gc_cmp_q, gc_cmp_d;
   logic               gc_dis_q, gc_dis_d;
   logic               succ_q, succ_d;
   logic               fail_q, fail_d;
   logic               disc_q, disc_d;
   logic               unexp_q, unexp_d;
   logic               serve;
   logic               tmr_load;
   logic               tmr_clear;
   logic               expired;
   logic [1:0]         lim;

   assign lim = (msg_retries < MAX_R) ? msg_retries : MAX_R;

   always_comb begin
      state_d  = state_q;
      msgid_d  = msgid_q;
      retry_d  = retry_q;
      start_d  = 1'b0;
      sel_d    = sel_q;
      id_d     = id_q;
      gc_cmp_d = 1'b0;
      gc_dis_d = 1'b0;
      succ_d   = 1'b0;
      fail_d   = 1'b0;
      disc_d   = 1'b0;
      unexp_d  = 1'b0;
      serve    = 1'b0;
      tmr_load = 1'b0;
      if (rx_goodcrc_valid && state_q != WAIT_CRC)
         unexp_d = 1'b1;
      unique case (state_q)
         IDLE: begin
            if (goodcrc_req) begin
               serve = 1'b1;
            end else if (msg_req) begin
               if (phy_bus_idle) begin
                  start_d = 1'b1;
                  sel_d   = PHY_SEL_MSG;
                  id_d    = msgid_q;
                  retry_d = 2'd0;
                  state_d = MSG_TX;
               end else begin
                  disc_d = 1'b1;
               end
            end
         end
         GCRC_TX: begin
            gc_dis_d = goodcrc_req;
            if (phy_tx_done) begin
               gc_cmp_d = 1'b1;
               state_d  = IDLE;
            end
         end
         MSG_TX: begin
            gc_dis_d = goodcrc_req;
            if (phy_tx_done) begin
               tmr_load = 1'b1;
               state_d  = WAIT_CRC;
            end
         end
         WAIT_CRC: begin
            if (goodcrc_req) begin
               disc_d  = 1'b1;
               unexp_d = rx_goodcrc_valid;
               serve   = 1'b1;
            end else if (rx_goodcrc_valid && rx_goodcrc_id == msgid_q) begin
               succ_d  = 1'b1;
               msgid_d = msgid_q + 3'd1;
               state_d = IDLE;
            end else begin
               unexp_d = rx_goodcrc_valid;
               if (expired) begin
                  if (retry_q < lim) begin
                     retry_d = retry_q + 2'd1;
                     state_d = RETRY;
                  end else begin
                     fail_d  = 1'b1;
                     msgid_d = msgid_q + 3'd1;
                     state_d = IDLE;
                  end
               end
            end
         end
         RETRY: begin
            if (goodcrc_req) begin
               disc_d = 1'b1;
               serve  = 1'b1;
            end else if (phy_bus_idle) begin
               start_d = 1'b1;
               sel_d   = PHY_SEL_MSG;
               id_d    = msgid_q;
               state_d = MSG_TX;
            end
         end
         default: state_d = IDLE;
      endcase
      // A GoodCRC request taken from IDLE, WAIT_CRC or RETRY.
      if (serve) begin
         state_d = IDLE;
         if (phy_bus_idle) begin
            start_d = 1'b1;
            sel_d   = PHY_SEL_GCRC;
            state_d = GCRC_TX;
         end else begin
            gc_dis_d = 1'b1;
         end
      end
`ifdef TCPC_MSGID_CLEAR_EN
      if (msgid_clear) begin
         msgid_d = '0;
         if (state_q == WAIT_CRC || state_q == RETRY) begin
            disc_d  = 1'b1;
            succ_d  = 1'b0;
            fail_d  = 1'b0;
            if (!serve)
               state_d = IDLE;
         end
      end
`endif
   end

   assign tmr_clear = (state_q == WAIT_CRC) && (state_d != WAIT_CRC);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         msgid_q  <= '0;
         retry_q  <= '0;
         start_q  <= 1'b0;
         sel_q    <= PHY_SEL_MSG;
         id_q     <= '0;
         gc_cmp_q <= 1'b0;
         gc_dis_q <= 1'b0;
         succ_q   <= 1'b0;
         fail_q   <= 1'b0;
         disc_q   <= 1'b0;
         unexp_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         msgid_q  <= msgid_d;
         retry_q  <= retry_d;
         start_q  <= start_d;
         sel_q    <= sel_d;
         id_q     <= id_d;
         gc_cmp_q <= gc_cmp_d;
         gc_dis_q <= gc_dis_d;
         succ_q   <= succ_d;
         fail_q   <= fail_d;
         disc_q   <= disc_d;
         unexp_q  <= unexp_d;
      end
   end

   crc_receive_timer #(
      .CRC_TIMEOUT (CRC_TIMEOUT)
   ) u_timer (
      .clk       (clk),
      .reset     (reset),
      .load_i    (tmr_load),
      .clear_i   (tmr_clear),
      .expired_o (expired)
   );

   assign phy_tx_start       = start_q;
   assign phy_tx_sel         = sel_q;
   assign phy_tx_id          = id_q;
   assign goodcrc_complete   = gc_cmp_q;
   assign goodcrc_discarded  = gc_dis_q;
   assign msg_success        = succ_q;
   assign msg_failed         = fail_q;
   assign msg_discarded      = disc_q;
   assign unexpected_goodcrc = unexp_q;

endmodule

// File: tb/tb_prl_tx_arbiter.sv
// Directed self-checking bench for prl_tx_arbiter.
module tb_prl_tx_arbiter;

   localparam int CT = 30;

   logic       clk = 1'b0;
   logic       reset;
   logic       goodcrc_req;
   logic       goodcrc_complete;
   logic       goodcrc_discarded;
   logic       msg_req;
   logic [1:0] msg_retries;
   logic       msg_success;
   logic       msg_failed;
   logic       msg_discarded;
   logic       rx_goodcrc_valid;
   logic [2:0] rx_goodcrc_id;
   logic       unexpected_goodcrc;
   logic       phy_bus_idle;
   logic       phy_tx_done;
   logic       phy_tx_start;
   logic       phy_tx_sel;
   logic [2:0] phy_tx_id;

   int n_chk  = 0;
   int n_pass = 0;

   prl_tx_arbiter #(
      .CRC_TIMEOUT (CT),
      .MAX_RETRY   (3)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .goodcrc_req        (goodcrc_req),
      .goodcrc_complete   (goodcrc_complete),
      .goodcrc_discarded  (goodcrc_discarded),
      .msg_req            (msg_req),
      .msg_retries        (msg_retries),
      .msg_success        (msg_success),
      .msg_failed         (msg_failed),
      .msg_discarded      (msg_discarded),
      .rx_goodcrc_valid   (rx_goodcrc_valid),
      .rx_goodcrc_id      (rx_goodcrc_id),
      .unexpected_goodcrc (unexpected_goodcrc),
      .phy_bus_idle       (phy_bus_idle),
      .phy_tx_done        (phy_tx_done),
`ifdef TCPC_MSGID_CLEAR_EN
      .msgid_clear        (1'b0),
`endif
      .phy_tx_start       (phy_tx_start),
      .phy_tx_sel         (phy_tx_sel),
      .phy_tx_id          (phy_tx_id)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      if (obs === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [10:0] outs();
      return {phy_tx_start, phy_tx_sel, phy_tx_id, goodcrc_complete,
              goodcrc_discarded, msg_success, msg_failed, msg_discarded,
              unexpected_goodcrc};
   endfunction

   task automatic pulse_done();
      phy_tx_done = 1'b1;
      tick();
      phy_tx_done = 1'b0;
   endtask

   initial begin
      int  cnt;
      logic seen;
      reset = 1'b1;
      goodcrc_req = 0; msg_req = 0; msg_retries = 2'd0;
      rx_goodcrc_valid = 0; rx_goodcrc_id = 3'd0;
      phy_bus_idle = 1'b1; phy_tx_done = 1'b0;
      repeat (3) tick();
      check("reset_outs", 32'(outs()), 32'd0);
      reset = 1'b0;
      tick();

      // GoodCRC with idle bus
      goodcrc_req = 1; tick(); goodcrc_req = 0;
      check("gcrc_start", 32'(phy_tx_start), 1);
      check("gcrc_sel", 32'(phy_tx_sel), 1);
      tick();
      check("gcrc_start_1cyc", 32'(phy_tx_start), 0);
      pulse_done();
      check("gcrc_complete", 32'(goodcrc_complete), 1);
      tick();
      check("gcrc_complete_1cyc", 32'(goodcrc_complete), 0);

      // Message acknowledged 20 cycles after done
      msg_req = 1; tick();
      check("msg0_start", 32'(phy_tx_start), 1);
      check("msg0_sel", 32'(phy_tx_sel), 0);
      check("msg0_id", 32'(phy_tx_id), 0);
      tick();
      pulse_done();
      repeat (19) tick();
      rx_goodcrc_valid = 1; rx_goodcrc_id = 3'd0; tick();
      rx_goodcrc_valid = 0; msg_req = 0;
      check("msg0_success", 32'(msg_success), 1);
      tick();
      check("msg0_success_1cyc", 32'(msg_success), 0);

      // Two retries then failure
      msg_retries = 2'd2;
      msg_req = 1; tick();
      check("msg1_start", 32'(phy_tx_start), 1);
      check("msg1_id", 32'(phy_tx_id), 1);
      for (int r = 0; r < 3; r++) begin
         tick();
         pulse_done();
         cnt = 0;
         while (cnt < CT + 5) begin
            tick();
            cnt++;
            if (phy_tx_start || msg_failed) break;
         end
         if (r < 2) begin
            check("retry_gap", 32'(cnt), 32'(CT + 1));
            check("retry_id", 32'(phy_tx_id), 1);
            check("retry_no_fail", 32'(msg_failed), 0);
         end else begin
            check("fail_gap", 32'(cnt), 32'(CT));
            check("failed", 32'(msg_failed), 1);
         end
      end
      msg_req = 0;
      tick();

      // GoodCRC and message together: GoodCRC wins
      goodcrc_req = 1; msg_req = 1; tick(); goodcrc_req = 0;
      check("both_gcrc_first", 32'({phy_tx_start, phy_tx_sel}), 32'b11);
      tick();
      pulse_done();
      check("both_gcrc_complete", 32'(goodcrc_complete), 1);
      check("both_no_start_yet", 32'(phy_tx_start), 0);
      tick();
      check("both_msg_start", 32'({phy_tx_start, phy_tx_sel}), 32'b10);
      check("both_msg_id", 32'(phy_tx_id), 2);

      // Mismatched GoodCRC, then match on the expiry cycle
      tick();
      pulse_done();
      repeat (4) tick();
      rx_goodcrc_valid = 1; rx_goodcrc_id = 3'd5; tick();
      rx_goodcrc_valid = 0;
      check("unexp_id5", 32'(unexpected_goodcrc), 1);
      check("unexp_no_success", 32'(msg_success), 0);
      repeat (CT - 6) tick();
      rx_goodcrc_valid = 1; rx_goodcrc_id = 3'd2; tick();
      rx_goodcrc_valid = 0; msg_req = 0;
      check("expiry_match_success", 32'(msg_success), 1);
      check("expiry_match_no_fail", 32'(msg_failed), 0);
      seen = 0;
      repeat (CT + 3) begin
         tick();
         seen = seen | phy_tx_start;
      end
      check("expiry_match_no_retry", 32'(seen), 0);

      // GoodCRC request pre-empts WAIT_CRC
      msg_req = 1; tick();
      check("msg3_id", 32'(phy_tx_id), 3);
      tick();
      pulse_done();
      repeat (3) tick();
      goodcrc_req = 1; tick(); goodcrc_req = 0; msg_req = 0;
      check("preempt_discard", 32'(msg_discarded), 1);
      check("preempt_gcrc_start", 32'({phy_tx_start, phy_tx_sel}), 32'b11);
      tick();
      pulse_done();
      check("preempt_gcrc_complete", 32'(goodcrc_complete), 1);

      // Reset mid-MSG_TX; msgid unchanged by the abandon
      msg_req = 1; tick(); msg_req = 0;
      check("msg_after_abandon_id", 32'(phy_tx_id), 3);
      tick();
      reset = 1; #1;
      check("reset_async_start", 32'(phy_tx_start), 0);
      tick();
      check("reset_mid_outs", 32'(outs()), 32'd0);
      reset = 0;
      tick();

      // Busy bus and stray GoodCRC
      phy_bus_idle = 0;
      goodcrc_req = 1; tick(); goodcrc_req = 0;
      check("gcrc_busy_discard", 32'({goodcrc_discarded, phy_tx_start}), 32'b10);
      msg_req = 1; tick(); msg_req = 0;
      check("msg_busy_discard", 32'({msg_discarded, phy_tx_start}), 32'b10);
      phy_bus_idle = 1;
      rx_goodcrc_valid = 1; rx_goodcrc_id = 3'd0; tick();
      rx_goodcrc_valid = 0;
      check("idle_unexp", 32'(unexpected_goodcrc), 1);

      // MessageID wraps 7 -> 0
      for (int i = 0; i < 9; i++) begin
         msg_req = 1; tick();
         check("wrap_id", 32'(phy_tx_id), 32'(i % 8));
         pulse_done();
         rx_goodcrc_valid = 1; rx_goodcrc_id = 3'(i % 8); tick();
         rx_goodcrc_valid = 0; msg_req = 0;
         check("wrap_success", 32'(msg_success), 1);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/prl_tx_arbiter.md
# prl_tx_arbiter

Protocol-layer PHY transmit arbiter for the TCPC. It shares the single BMC PHY transmitter between the Rx path's GoodCRC responses and the Tx path's outgoing messages. It also owns the CRCReceiveTimer, the retry counter and the 3-bit MessageIDCounter. It sits between the Rx/Tx protocol state machines and the PHY, and produces the GoodCRC and transmit status pulses those machines consume.

## Interface
- CRC_TIMEOUT, 1000: CRCReceiveTimer length in clk cycles, ≥2.
- MAX_RETRY, 3: hardware ceiling on retries; the effective limit is min(msg_retries, MAX_RETRY).
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- goodcrc_req  in  1  one-cycle pulse from Rx: send GoodCRC now.
- goodcrc_complete  out  1  pulse: GoodCRC transmission complete.
- goodcrc_discarded  out  1  pulse: GoodCRC dropped because the PHY was not free.
- msg_req  in  1  level from Tx, held until a terminal status pulse.
- msg_retries  in  2  retry count from register file.
- msg_success / msg_failed / msg_discarded  out  1 each  terminal status pulses.
- rx_goodcrc_valid  in  1  pulse: a GoodCRC was received.
- rx_goodcrc_id  in  3  MessageID of the received GoodCRC.
- unexpected_goodcrc  out  1  pulse: GoodCRC not matching an outstanding message.
- phy_bus_idle  in  1  CC line idle.
- phy_tx_done  in  1  pulse: PHY finished the current frame.
- phy_tx_start  out  1  pulse: begin a frame.
- phy_tx_sel  out  1  0 = message, 1 = GoodCRC; held stable while the PHY is busy.
- phy_tx_id  out  3  MessageID for the message frame.

## Operation
- FSM states: IDLE, GCRC_TX, MSG_TX, WAIT_CRC, RETRY.
- IDLE:
  - goodcrc_req has priority over msg_req.
  - goodcrc_req with phy_bus_idle=1: start with sel=1, go to GCRC_TX.
  - goodcrc_req with phy_bus_idle=0: pulse goodcrc_discarded.
  - Otherwise msg_req with phy_bus_idle=1: start with sel=0, id=msgid_cnt, retry_cnt=0, go to MSG_TX.
  - msg_req with phy_bus_idle=0: pulse msg_discarded.
- GCRC_TX: on phy_tx_done, pulse goodcrc_complete and return to IDLE.
- MSG_TX: on phy_tx_done, load timer=CRC_TIMEOUT and go to WAIT_CRC.
- WAIT_CRC: timer decrements every cycle.
  - rx_goodcrc_valid with id==msgid_cnt: pulse msg_success, msgid_cnt+1 mod 8, go to IDLE.
  - Mismatched id: pulse unexpected_goodcrc and stay.
- WAIT_CRC timeout:
  - retry_cnt < min(msg_retries, MAX_RETRY): retry_cnt+1, go to RETRY.
  - Otherwise: pulse msg_failed, msgid_cnt+1 mod 8, go to IDLE.
- RETRY: wait for phy_bus_idle, then start with the same id and go to MSG_TX.
- goodcrc_req in WAIT_CRC or RETRY (incoming message pre-empts):
  - Pulse msg_discarded.
  - Abandon the message; msgid_cnt is unchanged.
  - Serve the GoodCRC exactly as in IDLE, in the same cycle.
- goodcrc_req in MSG_TX or GCRC_TX: pulse goodcrc_discarded.
- rx_goodcrc_valid in any state other than WAIT_CRC: pulse unexpected_goodcrc.
- msgid_cnt wraps 7→0.

## Timing
- All outputs are registered.
- Reset values: every pulse output 0, phy_tx_sel 0, phy_tx_id 0, msgid_cnt 0, state IDLE.
- phy_tx_start and every status pulse assert the cycle after the qualifying input is sampled, for exactly one cycle.
- Timer loaded on the phy_tx_done cycle (T). Timeout is evaluated at T+CRC_TIMEOUT.
- A matching GoodCRC in that same cycle wins over timeout.
- msg_req is sampled only in IDLE. Tx must drop msg_req the cycle after a terminal pulse, or a new request is taken.
- Reset asserted mid-frame: phy_tx_start drops immediately and no status pulse is generated.

## Configuration
- TCPC_MSGID_CLEAR_EN defined: adds input msgid_clear (1 bit).
  - A pulse zeroes msgid_cnt in any state.
  - If in WAIT_CRC or RETRY, it also aborts with msg_discarded and returns to IDLE. This serves soft reset.
- Undefined: no port; msgid_cnt clears only on reset.

## Structure
- Package tcpc_prl_pkg holds:
  - the state encoding,
  - PHY_SEL_MSG/PHY_SEL_GCRC constants,
  - MSGID_W=3.
- Sub-module crc_receive_timer holds the timer:
  - Down-counter of width $clog2(CRC_TIMEOUT+1).
  - Inputs load and clear; output expired as a one-cycle pulse.

## Test plan
- Reset, then goodcrc_req with bus idle → phy_tx_start sel=1 at +1. phy_tx_done → goodcrc_complete one cycle.
- msg_req, bus idle, GoodCRC id 0 returned 20 cycles after done → msg_success. Next message carries id 1.
- msg_retries=2, no GoodCRC → three starts with the same id, each spaced CRC_TIMEOUT after done. Then msg_failed; msgid_cnt advances.
- goodcrc_req and msg_req in the same IDLE cycle → GoodCRC first; the message starts after goodcrc_complete.
- GoodCRC id 5 while expecting id 2 → unexpected_goodcrc and still in WAIT_CRC. Matching id 2 on the expiry cycle → msg_success, no retry.
- goodcrc_req in WAIT_CRC → msg_discarded and a GoodCRC start. Reset mid-MSG_TX → all outputs 0 next edge.
